// File: rtl/rvfi_trace_buffer.sv
// RVFI commit-trace capture into an on-chip circular buffer (FIFO or ring mode),
// stamped per record with capture cycles since arm, drained through valid/ready.
package rvfi_pkg;
  localparam int XLEN = 64;
  localparam int VLEN = 39;
  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [31:0]     insn;
    logic            trap;
    logic [XLEN-1:0] cause;
    logic [1:0]      mode;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [VLEN-1:0] pc_rdata;
  } rvfi_instr_t;
endpackage

module rvfi_trace_buffer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 64,
  parameter int TIMEOUT         = 2000000,
  parameter bit STOP_ON_ECALL   = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  rvfi_pkg::rvfi_instr_t       rvfi_i [NR_COMMIT_PORTS],
  input  logic                        arm_i,
  input  logic                        mode_i,
  input  logic                        stop_i,
  output logic                        out_valid_o,
  output logic [207:0]                out_data_o,
  input  logic                        out_ready_i,
  output logic                        capturing_o,
  output logic                        ecall_o,
  output logic                        timeout_o,
  output logic                        ext_stop_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [15:0]                 drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 208;
  localparam logic [31:0] STAMP_MAX = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, STOPPED} state_t;
  state_t state, state_n;

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [15:0]   drop_cnt, drop_n;
  logic [31:0]   stamp;
  logic          ring, ecall_f, timeout_f, ext_stop_f;
  logic          set_ecall, set_ext, set_timeout;
  logic          arm_go, pop, ecall_any, take, blocked;

  logic [NR_COMMIT_PORTS-1:0] ev, is_ecall, keep, wr_en;
  logic [AW-1:0] wr_addr [NR_COMMIT_PORTS];
  logic [RW-1:0] rec     [NR_COMMIT_PORTS];
  int            rank    [NR_COMMIT_PORTS];
  int            k, nwr, ndrop, radv, free_sl, total;

  function automatic logic [RW-1:0] pack_rec(input rvfi_pkg::rvfi_instr_t r,
                                             input logic [7:0] port,
                                             input logic [31:0] stamp_v);
    logic [RW-1:0] v;
    v            = '0;
    v[31:0]      = r.insn;
    v[95:32]     = 64'($signed(r.pc_rdata));
    v[159:96]    = r.trap ? 64'(r.cause) : 64'(r.rd_wdata);
    v[164:160]   = r.trap ? 5'd0 : r.rd_addr;
    v[166:165]   = r.mode;
    v[167]       = r.trap;
    v[175:168]   = port;
    v[207:176]   = stamp_v;
    return v;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s > 65535) return 16'hFFFF;
    return 16'(s);
  endfunction

  assign pop    = out_valid_o & out_ready_i;
  assign arm_go = arm_i && (state != CAPTURE);

  always_comb begin
    ecall_any = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      ev[i]       = rvfi_i[i].valid | rvfi_i[i].trap;
      is_ecall[i] = STOP_ON_ECALL && ev[i] && (rvfi_i[i].insn == 32'h0000_0073) &&
                    (rvfi_i[i].mode == rvfi_pkg::PRIV_LVL_M);
      ecall_any   = ecall_any | is_ecall[i];
    end
  end

  // Event selection: everything up to and including the first ECALL; stop_i
  // suppresses capture unless an ECALL outranks it in the same cycle.
  always_comb begin
    take    = (state == CAPTURE) && (ecall_any || !stop_i);
    k       = 0;
    blocked = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      rank[i] = k;
      keep[i] = 1'b0;
      if (take && ev[i] && !blocked) begin
        keep[i] = 1'b1;
        k       = k + 1;
        blocked = is_ecall[i];
      end
    end

    free_sl = DEPTH - int'(count);
    total   = int'(count) - int'(pop) + k;
    nwr     = k;
    ndrop   = 0;
    radv    = int'(pop);
    count_n = CW'(total);
    if (!ring) begin
      // Free space is judged before the pop, so a full buffer drops everything.
      if (k > free_sl) begin
        nwr   = free_sl;
        ndrop = k - free_sl;
      end
      count_n = CW'(int'(count) - int'(pop) + nwr);
    end else if (total > DEPTH) begin
      ndrop   = total - DEPTH;
      radv    = int'(pop) + ndrop;
      count_n = CW'(DEPTH);
    end

    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      wr_en[i]   = keep[i] && (rank[i] < nwr);
      wr_addr[i] = wr_ptr + AW'(rank[i]);
      rec[i]     = pack_rec(rvfi_i[i], 8'(i), stamp);
    end
    wr_ptr_n = wr_ptr + AW'(nwr);
    rd_ptr_n = rd_ptr + AW'(radv);
    drop_n   = sat_add16(drop_cnt, ndrop);
  end

  always_comb begin
    state_n     = state;
    set_ecall   = 1'b0;
    set_ext     = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE, STOPPED: begin
        if (arm_i) state_n = CAPTURE;
      end
      CAPTURE: begin
        if (ecall_any) begin
          state_n   = STOPPED;
          set_ecall = 1'b1;
        end else if (stop_i) begin
          state_n = STOPPED;
          set_ext = 1'b1;
        end else if (stamp == STAMP_MAX) begin
          state_n     = STOPPED;
          set_timeout = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || arm_go) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      stamp      <= '0;
      ecall_f    <= 1'b0;
      timeout_f  <= 1'b0;
      ext_stop_f <= 1'b0;
      ring       <= rst_i ? 1'b0 : mode_i;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count      <= count_n;
      drop_cnt   <= drop_n;
      ecall_f    <= ecall_f | set_ecall;
      timeout_f  <= timeout_f | set_timeout;
      ext_stop_f <= ext_stop_f | set_ext;
      if (state == CAPTURE && stamp != STAMP_MAX) stamp <= stamp + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= rec[i];
    end
  end

  assign out_valid_o = (count != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
  assign capturing_o = (state == CAPTURE);
  assign ecall_o     = ecall_f;
  assign timeout_o   = timeout_f;
  assign ext_stop_o  = ext_stop_f;
  assign count_o     = count;
  assign drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: single-record vector table, scoreboard-driven
// FIFO/ring/ECALL/timeout sequences, stop, re-arm and mid-capture reset.
module tb_rvfi_trace_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rvfi_pkg::rvfi_instr_t rvfi [2];
  logic arm = 1'b0, mode = 1'b0, stop = 1'b0, out_ready = 1'b0, ready_t = 1'b0;
  logic out_valid, capturing, ecall, timeout, ext_stop;
  logic [207:0] out_data;
  logic [6:0] count;
  logic [15:0] drop;
  logic out_valid_t, capturing_t, ecall_t, timeout_t, ext_stop_t;
  logic [207:0] out_data_t;
  logic [6:0] count_t;
  logic [15:0] drop_t;

  int checks = 0;
  int errors = 0;
  int stamp_m = 0;
  int drops_m = 0;
  logic ring_m = 1'b0;
  logic [207:0] exp_q[$];

  always #5 clk = ~clk;

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(2), .DEPTH(64), .TIMEOUT(100000)) dut (
    .clk_i(clk), .rst_i(rst), .rvfi_i(rvfi), .arm_i(arm), .mode_i(mode), .stop_i(stop),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .capturing_o(capturing), .ecall_o(ecall), .timeout_o(timeout), .ext_stop_o(ext_stop),
    .count_o(count), .drop_cnt_o(drop));

  rvfi_trace_buffer #(.NR_COMMIT_PORTS(2), .DEPTH(64), .TIMEOUT(10)) dut_t (
    .clk_i(clk), .rst_i(rst), .rvfi_i(rvfi), .arm_i(arm), .mode_i(mode), .stop_i(stop),
    .out_valid_o(out_valid_t), .out_data_o(out_data_t), .out_ready_i(ready_t),
    .capturing_o(capturing_t), .ecall_o(ecall_t), .timeout_o(timeout_t), .ext_stop_o(ext_stop_t),
    .count_o(count_t), .drop_cnt_o(drop_t));

  typedef struct {
    logic        vld;
    logic        trp;
    logic [31:0] insn;
    logic [38:0] pc;
    logic [63:0] cause;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [1:0]  md;
    logic [207:0] exp_rec;
    logic        exp_cap;
  } vec_t;
  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [207:0] act, input logic [207:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chkv(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [207:0] mk_rec(input logic [31:0] insn, input logic [38:0] pc,
      input logic trp, input logic [63:0] cause, input logic [4:0] rd, input logic [63:0] wd,
      input logic [1:0] md, input int port, input int stmp);
    logic [207:0] r;
    r = '0;
    r[31:0]    = insn;
    r[95:32]   = {{25{pc[38]}}, pc};
    r[159:96]  = trp ? cause : wd;
    r[164:160] = trp ? 5'd0 : rd;
    r[166:165] = md;
    r[167]     = trp;
    r[175:168] = 8'(port);
    r[207:176] = 32'(stmp);
    return r;
  endfunction

  task automatic set_port(input int p, input logic v, input logic t, input logic [31:0] insn,
      input logic [38:0] pc, input logic [63:0] cause, input logic [4:0] rd,
      input logic [63:0] wd, input logic [1:0] md);
    rvfi[p].valid = v;    rvfi[p].trap = t;      rvfi[p].insn = insn;
    rvfi[p].pc_rdata = pc; rvfi[p].cause = cause; rvfi[p].rd_addr = rd;
    rvfi[p].rd_wdata = wd; rvfi[p].mode = md;
  endtask

  task automatic clear_ports();
    rvfi[0] = '0;
    rvfi[1] = '0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_arm(input logic m);
    arm = 1'b1;
    mode = m;
    tick();
    arm = 1'b0;
    stamp_m = 0;
    drops_m = 0;
    ring_m = m;
    exp_q.delete();
  endtask

  // One capture cycle with generated events; the model predicts what is stored.
  task automatic cycle_events(input logic v0, input logic v1, input logic do_pop);
    logic [1:0] v;
    logic [31:0] insn;
    logic [38:0] pc;
    logic [4:0] rd;
    logic [63:0] wd;
    logic [207:0] r;
    int free;
    v = {v1, v0};
    free = 64 - exp_q.size();
    if (do_pop) chk("pop_head", out_data, exp_q.size() > 0 ? exp_q[0] : '0);
    if (ring_m && do_pop && exp_q.size() > 0) r = exp_q.pop_front();
    for (int p = 0; p < 2; p++) begin
      if (v[p]) begin
        insn = {8'h10, 16'(stamp_m), 7'h0, 1'(p)};
        pc   = 39'(32'h1000 + stamp_m * 8 + p * 4);
        rd   = 5'(stamp_m + p + 1);
        wd   = {16'hC0DE, 16'(p), 32'(stamp_m)};
        set_port(p, 1'b1, 1'b0, insn, pc, 64'h0, rd, wd, 2'b11);
        r = mk_rec(insn, pc, 1'b0, 64'h0, rd, wd, 2'b11, p, stamp_m);
        if (ring_m) begin
          exp_q.push_back(r);
          if (exp_q.size() > 64) begin
            r = exp_q.pop_front();
            drops_m++;
          end
        end else if (free > 0) begin
          exp_q.push_back(r);
          free--;
        end else begin
          drops_m++;
        end
      end
    end
    if (!ring_m && do_pop && exp_q.size() > 0) r = exp_q.pop_front();
    out_ready = do_pop;
    tick();
    out_ready = 1'b0;
    clear_ports();
    stamp_m++;
  endtask

  task automatic drain(input string nm);
    int n;
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      chk(nm, out_data, exp_q.pop_front());
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chkv({nm, "_empty_count"}, int'(count), 0);
    chkv({nm, "_empty_valid"}, int'(out_valid), 0);
  endtask

  task automatic check_reset(input string nm);
    chkv({nm, "_valid"}, int'(out_valid), 0);
    chk({nm, "_data"}, out_data, '0);
    chkv({nm, "_count"}, int'(count), 0);
    chkv({nm, "_drop"}, int'(drop), 0);
    chkv({nm, "_flags"}, int'({capturing, ecall, timeout, ext_stop}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h00A00093, 39'h00_0000_1000, 64'h0, 5'd1, 64'h10, 2'b11,
                {32'h0, 8'h0, 1'b0, 2'b11, 5'd1, 64'h10, 64'h0000000000001000, 32'h00A00093}, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 32'h00000000, 39'h00_8000_0004, 64'h2, 5'd7, 64'hAAAA, 2'b11,
                {32'h0, 8'h0, 1'b1, 2'b11, 5'd0, 64'h2, 64'h0000000080000004, 32'h00000000}, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h00000013, 39'h40_0000_0100, 64'h0, 5'd31, 64'hFFFFFFFFFFFFFFFF, 2'b00,
                {32'h0, 8'h0, 1'b0, 2'b00, 5'd31, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFC000000100, 32'h00000013}, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 32'h12345678, 39'h00_0000_2000, 64'h800000000000000B, 5'd3, 64'h5, 2'b01,
                {32'h0, 8'h0, 1'b1, 2'b01, 5'd0, 64'h800000000000000B, 64'h0000000000002000, 32'h12345678}, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h00000073, 39'h00_0000_3000, 64'h0, 5'd0, 64'h0, 2'b00,
                {32'h0, 8'h0, 1'b0, 2'b00, 5'd0, 64'h0, 64'h0000000000003000, 32'h00000073}, 1'b1};
    clear_ports();
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h13, 39'h100, 64'h0, 5'd1, 64'h1, 2'b11);
    set_port(1, 1'b1, 1'b0, 32'h13, 39'h104, 64'h0, 5'd2, 64'h2, 2'b11);
    tick();
    clear_ports();
    chkv("idle_ignored", int'(count), 0);

    for (int i = 0; i < 5; i++) begin
      do_stop();
      do_arm(1'b0);
      set_port(0, vecs[i].vld, vecs[i].trp, vecs[i].insn, vecs[i].pc, vecs[i].cause,
               vecs[i].rd, vecs[i].wdata, vecs[i].md);
      tick();
      clear_ports();
      chkv($sformatf("vec%0d_count", i), int'(count), 1);
      chk($sformatf("vec%0d_rec", i), out_data, vecs[i].exp_rec);
      chkv($sformatf("vec%0d_cap", i), int'(capturing), int'(vecs[i].exp_cap));
    end

    do_stop();
    do_arm(1'b0);
    for (int c = 0; c < 40; c++) cycle_events(1'b1, 1'b1, 1'b0);
    chkv("fifo_count", int'(count), 64);
    chkv("fifo_drop", int'(drop), 16);
    chkv("fifo_cap", int'(capturing), 1);
    cycle_events(1'b1, 1'b1, 1'b1);
    chkv("fifo_fullpop_count", int'(count), 63);
    chkv("fifo_fullpop_drop", int'(drop), drops_m);
    chkv("fifo_fullpop_drop18", int'(drop), 18);
    drain("fifo_drain");

    do_stop();
    do_arm(1'b1);
    for (int c = 0; c < 40; c++) cycle_events(1'b1, 1'b1, 1'b0);
    chkv("ring_count", int'(count), 64);
    chkv("ring_drop", int'(drop), 16);
    chkv("ring_head_stamp", int'(out_data[207:176]), 8);
    chkv("ring_head_port", int'(out_data[175:168]), 0);
    cycle_events(1'b1, 1'b1, 1'b1);
    chkv("ring_pop_count", int'(count), 64);
    chkv("ring_pop_drop", int'(drop), 17);
    drain("ring_drain");

    do_stop();
    do_arm(1'b0);
    cycle_events(1'b1, 1'b1, 1'b0);
    set_port(0, 1'b1, 1'b0, 32'h73, 39'h4000, 64'h0, 5'd0, 64'h0, 2'b11);
    set_port(1, 1'b1, 1'b0, 32'h13, 39'h4004, 64'h0, 5'd9, 64'h99, 2'b11);
    exp_q.push_back(mk_rec(32'h73, 39'h4000, 1'b0, 64'h0, 5'd0, 64'h0, 2'b11, 0, stamp_m));
    tick();
    clear_ports();
    chkv("ecall_flag", int'(ecall), 1);
    chkv("ecall_cap", int'(capturing), 0);
    chkv("ecall_count", int'(count), 3);
    chkv("ecall_drop", int'(drop), 0);
    chkv("ecall_other_flags", int'({timeout, ext_stop}), 0);
    set_port(0, 1'b1, 1'b0, 32'h13, 39'h5000, 64'h0, 5'd1, 64'h1, 2'b11);
    tick();
    clear_ports();
    chkv("stopped_ignored", int'(count), 3);
    drain("ecall_drain");

    do_stop();
    do_arm(1'b0);
    for (int c = 0; c < 12; c++) cycle_events(1'b1, 1'b0, 1'b0);
    chkv("tmo_count", int'(count_t), 10);
    chkv("tmo_flag", int'(timeout_t), 1);
    chkv("tmo_cap", int'(capturing_t), 0);
    chkv("tmo_main_count", int'(count), 12);
    chkv("tmo_main_flag", int'(timeout), 0);
    for (int j = 0; j < 10; j++) begin
      chkv($sformatf("tmo_stamp%0d", j), int'(out_data_t[207:176]), j);
      ready_t = 1'b1;
      tick();
      ready_t = 1'b0;
    end
    chkv("tmo_empty", int'(out_valid_t), 0);
    drain("tmo_main_drain");

    do_stop();
    do_arm(1'b0);
    for (int c = 0; c < 33; c++) cycle_events(1'b1, 1'b1, 1'b0);
    chkv("pre_stop_drop", int'(drop), 2);
    set_port(0, 1'b1, 1'b0, 32'h13, 39'h6000, 64'h0, 5'd1, 64'h1, 2'b11);
    set_port(1, 1'b1, 1'b0, 32'h13, 39'h6004, 64'h0, 5'd2, 64'h2, 2'b11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    clear_ports();
    chkv("stop_count", int'(count), 64);
    chkv("stop_drop", int'(drop), 2);
    chkv("stop_flags", int'({capturing, ecall, timeout, ext_stop}), 1);
    do_arm(1'b0);
    chkv("rearm_count", int'(count), 0);
    chkv("rearm_drop", int'(drop), 0);
    chkv("rearm_flags", int'({capturing, ecall, timeout, ext_stop}), 8);
    chkv("rearm_valid", int'(out_valid), 0);

    set_port(0, 1'b0, 1'b1, 32'h0, 39'h00_8000_0004, 64'h2, 5'd4, 64'h77, 2'b11);
    tick();
    clear_ports();
    chkv("trap_bit", int'(out_data[167]), 1);
    chk("trap_cause", 208'(out_data[159:96]), 208'(64'h2));
    chk("trap_pc", 208'(out_data[95:32]), 208'(64'h0000000080000004));
    chkv("trap_rd", int'(out_data[164:160]), 0);
    rst = 1'b1;
    tick();
    check_reset("midreset");
    rst = 1'b0;
    tick();
    check_reset("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
